// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage, owning the architectural HI/LO registers.
// Shift-add multiply and restoring divide take one iteration per operand bit, then a sign-fix cycle.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             EX_Start,
    input  logic [2:0]       EX_MDOp,
    input  logic [WIDTH-1:0] EX_OpA,
    input  logic [WIDTH-1:0] EX_OpB,
    input  logic             Flush,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FINISH} state_e;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               is_div_q, neg_res_q, neg_rem_q, done_q;

    logic               op_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH+1:0]   trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        op_signed = ~EX_MDOp[0];
        a_neg     = op_signed & EX_OpA[WIDTH-1];
        b_neg     = op_signed & EX_OpB[WIDTH-1];
        mag_a     = a_neg ? -EX_OpA : EX_OpA;
        mag_b     = b_neg ? -EX_OpB : EX_OpB;

        // Divide keeps {remainder, quotient} in acc; dividend bits stream in from opa_q MSB.
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
        trial     = {1'b0, rem_shift} - {2'b00, opb_q};

        if (is_div_q) begin
            acc_d = trial[WIDTH+1] ? {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0],     acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = acc_q + (opb_q[0] ? opa_q : '0);
        end

        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (EX_Start && !Flush) begin
                        case (EX_MDOp)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                opa_q     <= {{WIDTH{1'b0}}, mag_a};
                                opb_q     <= mag_b;
                                acc_q     <= '0;
                                cnt_q     <= '0;
                                is_div_q  <= EX_MDOp[1];
                                neg_res_q <= a_neg ^ b_neg;
                                neg_rem_q <= a_neg;
                                state_q   <= S_BUSY;
                            end
                            OP_MTHI: hi_q <= EX_OpA;
                            OP_MTLO: lo_q <= EX_OpA;
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    if (Flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        opa_q <= opa_q << 1;
                        if (!is_div_q) opb_q <= opb_q >> 1;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                    if (!Flush) begin
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Stall = (state_q != S_IDLE);
    assign Done  = done_q;
    assign HI    = hi_q;
    assign LO    = lo_q;

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage of the pipelined MIPS datapath. It consumes the operand and control values that the ID/EX pipeline register presents to EX, computes MULT/MULTU/DIV/DIVU results over 32 iterations, and holds them in architectural HI/LO registers. It also handles MTHI/MTLO writes. While an operation is in flight it drives a stall so the hazard logic freezes the PC, IF/ID and ID/EX registers.

## Interface
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous, active-low reset.
- EX_Start  in  1  operation request; valid only when EX_MDOp is a supported code.
- EX_MDOp  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are ignored.
- EX_OpA  in  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO source.
- EX_OpB  in  WIDTH  rt value: multiplier or divisor.
- Flush  in  1  aborts any in-flight operation.
- Stall  out  1  high while the unit is busy.
- Done  out  1  one-cycle pulse after HI/LO update for a mult/div.
- HI  out  WIDTH  architectural HI register.
- LO  out  WIDTH  architectural LO register.

## Operation
- States:
  - IDLE.
  - BUSY: 32 iterations, 5-bit counter.
  - FINISH: sign correction and HI/LO write.
- IDLE:
  - EX_Start with MULT/MULTU/DIV/DIVU: capture operand magnitudes. For signed ops use |x| of the two's-complement value, so 0x80000000 becomes 2^31 unsigned.
  - On the same start, capture the result-sign flags, clear the 64-bit accumulator and counter, and go to BUSY.
  - EX_Start with MTHI/MTLO: HI (resp. LO) <= EX_OpA at that edge. State stays IDLE. No Stall, no Done.
  - Unsupported codes, or EX_Start low: no action.
- BUSY, multiply: shift-add. Each iteration adds the shifted multiplicand if the current multiplier bit is 1, producing a 64-bit unsigned product.
- BUSY, divide: restoring division. Each iteration does shift remainder:quotient left, trial subtract the divisor, and keep the result if it is non-negative (setting the quotient bit).
- Counter reaches 31 → FINISH.
- FINISH, multiply: negate the 64-bit product if the signed op has differing operand signs. HI = upper word, LO = lower word.
- FINISH, divide:
  - Negate the quotient if the signed op has differing signs.
  - Negate the remainder if the signed op has a negative dividend.
  - LO = quotient, HI = remainder.
  - Then go to IDLE and pulse Done.
- Divide by zero (EX_OpB = 0, signed or unsigned): the result falls out of the algorithm with no special casing.
  - DIVU: LO = 0xFFFFFFFF, HI = EX_OpA.
  - DIV: the same raw values, then sign correction is applied.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0x00000000.
- EX_Start while BUSY or FINISH is ignored, including MTHI/MTLO.
- Flush:
  - In BUSY or FINISH: next state IDLE. HI/LO unchanged, no Done.
  - In IDLE: overrides EX_Start, so nothing is started or written.
- All arithmetic is modulo 2^WIDTH per word; no exceptions are raised.

## Timing
- Reset (asynchronous on Rst_n low):
  - State IDLE.
  - HI = 0, LO = 0.
  - Stall = 0, Done = 0.
  - Counter and accumulators = 0.
- Reset applied mid-operation aborts it immediately and HI/LO read 0.
- Start sampled at edge E0.
  - Stall is registered: high from after E0 through E33, i.e. it is (state != IDLE).
  - Iterations occur at E1..E32.
  - FINISH writes HI/LO at E33.
  - Done is high for the single cycle after E33.
  - Total latency is 33 edges from the start edge to the result.
- Hazard logic must hold the starting instruction's successor in ID/EX while Stall=1. The unit itself does not re-sample operands after E0.
- A new start can be accepted at E34, the first edge with state IDLE.
- MTHI/MTLO: results are visible the cycle after the sampling edge.

## Test plan
- Reset, then EX_Start MULT with A=0xFFFFFFFD (-3), B=7 → Stall high for 33 cycles; Done 1 cycle after E33; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU with A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV with A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV with 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x12345678 / 0 → LO=0xFFFFFFFF, HI=0x12345678.
- MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A → registers update on the next cycle, Stall stays 0.
- Start MULT, then an MTLO with EX_Start at iteration 5 → MTLO ignored, product written as normal.
- Start DIV, assert Flush at iteration 10 → IDLE next cycle, HI/LO hold their prior values, no Done.
- Start MULT, drop Rst_n at iteration 20 → outputs 0 immediately.
